fpu_escape_queue: RTL and testbench
===================================

# fpu_escape_queue

Parametrised successor to the single-slot CPU-to-FPU escape adapter. It buffers up to DEPTH ESC instructions (opcode and ModR/M) from the CPU and issues them in order to the FPU over a valid/ack handshake. It tracks FPU execution, enforces WAIT/FWAIT synchronisation and flow-control stalls through cpu_ready, and recovers from a hung FPU with a watchdog. It sits between the CPU core's escape decode and the integrated FPU's instruction port.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2
- TIMEOUT, 1024: cycles allowed in ISSUE+EXEC before abort; at least 2
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_fpu_escape  in  1  one-cycle pulse per ESC instruction
- cpu_opcode  in  8  ESC opcode (D8–DF), sampled with cpu_fpu_escape
- cpu_modrm  in  8  ModR/M, sampled with cpu_fpu_escape
- cpu_fwait  in  1  level; CPU is executing WAIT/FWAIT
- cpu_ready  out  1  low = CPU must stall
- fpu_instr_valid  out  1  instruction offered to FPU
- fpu_opcode  out  8  issued opcode, held stable while valid
- fpu_modrm  out  8  issued ModR/M, held stable while valid
- fpu_instr_ack  in  1  FPU accepts the instruction (sampled while valid)
- fpu_busy  in  1  FPU executing
- queue_level  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky: escape arrived while the queue was full
- timeout  out  1  sticky: watchdog abort occurred
- clear_err  in  1  synchronous clear of overflow and timeout

## Operation
- FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap naturally. Count is a registered value 0..DEPTH. full = (count==DEPTH), empty = (count==0).
- Push: cpu_fpu_escape with !full writes {opcode, modrm} at the write pointer. With full, the entry is dropped and overflow is set. There is no bypass: every entry passes through the FIFO.
- Pop: occurs only on the IDLE→ISSUE transition. The head is loaded into the fpu_opcode/fpu_modrm output registers.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. A push while full is dropped even if a pop happens in the same cycle.
- Issue FSM states and transitions:
  - IDLE: fpu_instr_valid=0. If !empty, pop and go to ISSUE.
  - ISSUE: fpu_instr_valid=1. On fpu_instr_ack, go to EXEC.
  - EXEC: fpu_instr_valid=0. Starting with the cycle after ack, the first cycle with fpu_busy==0 returns to IDLE.
  - The FPU must raise fpu_busy no later than the cycle it asserts ack.
- Watchdog:
  - Counter clears on entering ISSUE and increments every cycle in ISSUE or EXEC.
  - When it reaches TIMEOUT-1, the FSM returns to IDLE, drops the in-flight instruction, and sets timeout.
  - Queued entries are preserved.
- cpu_ready = !full && !(cpu_fwait && (!empty || state!=IDLE || fpu_busy)). Combinational from registered state and inputs.
- clear_err clears both sticky flags. A same-cycle set event wins over clear_err.
- Reset values: state IDLE, pointers 0, count 0, fpu_instr_valid 0, fpu_opcode 8'h00, fpu_modrm 8'h00, overflow 0, timeout 0, watchdog 0. cpu_ready is therefore 1.
- Reset asserted mid-operation discards the queue and any in-flight instruction immediately, regardless of clock.

## Timing
- Push at edge N: queue_level increments after edge N.
- Empty queue, IDLE, push at edge N: IDLE→ISSUE at edge N+1, so fpu_instr_valid is high during cycle N+1 and queue_level returns to 0 after N+1.
- Ack sampled at edge M: valid low after M. EXEC→IDLE at the first edge ≥ M+1 that samples fpu_busy==0. The next entry (if any) is valid one edge later.
- Minimum issue-to-issue spacing: 3 cycles (ISSUE, EXEC, IDLE).
- cpu_fwait stall releases in the cycle after the FSM reaches IDLE with the queue empty and fpu_busy low.

## Test plan
- Single FLD1: escape D9/E8 at edge N, FPU acks at N+2, busy low at N+4 → fpu_instr_valid high only in cycles N+1..N+2, fpu_opcode=D9, fpu_modrm=E8, state IDLE by N+5, cpu_ready=1 throughout.
- Burst, DEPTH=4: five back-to-back escapes (D9/E8, D9/EE, DE/C1, DD/D8, D9/E0) with ack withheld → queue_level reaches 4, cpu_ready low at full, overflow=1. After release, the issued order is D9/E8, D9/EE, DE/C1, DD/D8; D9/E0 is never issued.
- FWAIT sync: two queued instructions plus cpu_fwait=1 → cpu_ready=0 until the second completes and fpu_busy=0, then 1 in the following cycle.
- Watchdog, TIMEOUT=16: escape issued, ack never asserted → valid drops after 16 cycles in ISSUE, timeout=1, the next queued entry issues normally. clear_err → timeout=0.
- Reset mid-ISSUE: reset_n low between edges while valid=1 and level=2 → valid, queue_level, overflow and timeout are 0 immediately. After release, no instruction issues without a new escape.
- Simultaneous push/pop: level=1, IDLE, escape in the popping cycle → queue_level stays 1, pointers wrap correctly over 2·DEPTH operations.

Source files
------------

// File: rtl/fpu_escape_queue_if.sv
// CPU-to-FPU escape handshake bundle.
// slave is the queue; master is the CPU/FPU side.
interface fpu_escape_queue_if;
  logic       cpu_fpu_escape;
  logic [7:0] cpu_opcode;
  logic [7:0] cpu_modrm;
  logic       cpu_fwait;
  logic       cpu_ready;
  logic       fpu_instr_valid;
  logic [7:0] fpu_opcode;
  logic [7:0] fpu_modrm;
  logic       fpu_instr_ack;
  logic       fpu_busy;

  modport master (
    output cpu_fpu_escape,
    output cpu_opcode,
    output cpu_modrm,
    output cpu_fwait,
    output fpu_instr_ack,
    output fpu_busy,
    input  cpu_ready,
    input  fpu_instr_valid,
    input  fpu_opcode,
    input  fpu_modrm
  );

  modport slave (
    input  cpu_fpu_escape,
    input  cpu_opcode,
    input  cpu_modrm,
    input  cpu_fwait,
    input  fpu_instr_ack,
    input  fpu_busy,
    output cpu_ready,
    output fpu_instr_valid,
    output fpu_opcode,
    output fpu_modrm
  );
endinterface

// File: rtl/fpu_escape_queue.sv
// Buffers ESC instructions and issues them in order to the FPU,
// with FWAIT stalls and a watchdog for a hung FPU.
module fpu_escape_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  fpu_escape_queue_if.slave        bus,
  input  logic                     clear_err,
  output logic [$clog2(DEPTH):0]   queue_level,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    EXEC
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [WW-1:0]   wd;
  logic [7:0]      op_q, md_q;
  logic            full, empty;
  logic            push, pop;
  logic            wd_hit, ovf_set, tmo_set;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = bus.cpu_fpu_escape && !full;
  assign ovf_set = bus.cpu_fpu_escape && full;
  assign wd_hit  = (wd == WD_MAX);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmo_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wd_hit) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else if (bus.fpu_instr_ack) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (wd_hit) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else if (!bus.fpu_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wd      <= '0;
      op_q    <= 8'h00;
      md_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        op_q   <= mem[rd_ptr][15:8];
        md_q   <= mem[rd_ptr][7:0];
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop)                  wd <= '0;
      else if (state_q != IDLE) wd <= wd + 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cpu_opcode, bus.cpu_modrm};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (tmo_set)        timeout  <= 1'b1;
      else if (clear_err) timeout  <= 1'b0;
    end
  end

  assign queue_level         = count;
  assign bus.fpu_instr_valid = (state_q == ISSUE);
  assign bus.fpu_opcode      = op_q;
  assign bus.fpu_modrm       = md_q;
  assign bus.cpu_ready       = !full &&
    !(bus.cpu_fwait &&
      (!empty || state_q != IDLE || bus.fpu_busy));

endmodule

// File: tb/tb_fpu_escape_queue.sv
// Directed bench for fpu_escape_queue (DEPTH=4, TIMEOUT=16).
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_fpu_escape_queue;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear_err = 1'b0;
  logic [2:0] queue_level;
  logic       overflow;
  logic       timeout;
  int         total = 0;
  int         bad = 0;
  int         n;
  logic [15:0] got;
  logic [15:0] exp_b [4] = '{16'hD9E8, 16'hD9EE, 16'hDEC1, 16'hDDD8};

  fpu_escape_queue_if bus();

  fpu_escape_queue #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .clear_err   (clear_err),
    .queue_level (queue_level),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic esc(input logic [7:0] op, input logic [7:0] md);
    bus.cpu_fpu_escape = 1'b1;
    bus.cpu_opcode     = op;
    bus.cpu_modrm      = md;
    step();
    bus.cpu_fpu_escape = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.fpu_instr_valid && k < 32) begin
      step();
      k++;
    end
    check("wait_valid", 32'(bus.fpu_instr_valid), 1);
  endtask

  task automatic serve(output logic [15:0] ins);
    wait_valid();
    ins = {bus.fpu_opcode, bus.fpu_modrm};
    bus.fpu_instr_ack = 1'b1;
    bus.fpu_busy      = 1'b1;
    step();
    bus.fpu_instr_ack = 1'b0;
    bus.fpu_busy      = 1'b0;
    step();
  endtask

  function automatic logic [15:0] ent(input int i);
    return {8'hD8 | 8'(i & 7), 8'(8'h40 + i)};
  endfunction

  initial begin
    bus.cpu_fpu_escape = 1'b0;
    bus.cpu_opcode     = 8'h00;
    bus.cpu_modrm      = 8'h00;
    bus.cpu_fwait      = 1'b0;
    bus.fpu_instr_ack  = 1'b0;
    bus.fpu_busy       = 1'b0;
    repeat (2) step();
    check("rst_valid", 32'(bus.fpu_instr_valid), 0);
    check("rst_level", 32'(queue_level), 0);
    check("rst_op", 32'({bus.fpu_opcode, bus.fpu_modrm}), 0);
    check("rst_ready", 32'(bus.cpu_ready), 1);
    check("rst_flags", 32'({overflow, timeout}), 0);
    #2 reset_n = 1'b1;
    step();

    // single FLD1
    esc(8'hD9, 8'hE8);
    check("t1_lvl_n", 32'(queue_level), 1);
    check("t1_val_n", 32'(bus.fpu_instr_valid), 0);
    check("t1_rdy_n", 32'(bus.cpu_ready), 1);
    step();
    check("t1_val_n1", 32'(bus.fpu_instr_valid), 1);
    check("t1_lvl_n1", 32'(queue_level), 0);
    check("t1_ins", 32'({bus.fpu_opcode, bus.fpu_modrm}), 32'hD9E8);
    bus.fpu_instr_ack = 1'b1;
    bus.fpu_busy      = 1'b1;
    step();
    check("t1_val_n2", 32'(bus.fpu_instr_valid), 0);
    bus.fpu_instr_ack = 1'b0;
    step();
    bus.fpu_busy = 1'b0;
    step();
    check("t1_rdy_n4", 32'(bus.cpu_ready), 1);
    step();
    check("t1_val_n5", 32'(bus.fpu_instr_valid), 0);

    // burst into a full queue while the FPU is busy
    esc(8'hD9, 8'hC9);
    step();
    bus.fpu_instr_ack = 1'b1;
    bus.fpu_busy      = 1'b1;
    step();
    bus.fpu_instr_ack = 1'b0;
    for (int i = 0; i < 4; i++)
      esc(exp_b[i][15:8], exp_b[i][7:0]);
    check("t2_lvl4", 32'(queue_level), 4);
    check("t2_rdy_full", 32'(bus.cpu_ready), 0);
    check("t2_ovf_pre", 32'(overflow), 0);
    esc(8'hD9, 8'hE0);
    check("t2_lvl_ovf", 32'(queue_level), 4);
    check("t2_ovf", 32'(overflow), 1);
    bus.fpu_busy = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      serve(got);
      check($sformatf("t2_order%0d", i), 32'(got), 32'(exp_b[i]));
    end
    n = 0;
    repeat (6) begin
      if (bus.fpu_instr_valid) n++;
      step();
    end
    check("t2_no_5th", n, 0);
    check("t2_lvl_end", 32'(queue_level), 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 0);

    // FWAIT with two queued instructions
    esc(8'hD8, 8'hC1);
    esc(8'hDC, 8'hC9);
    bus.cpu_fwait = 1'b1;
    #1;
    check("t3_rdy_a", 32'(bus.cpu_ready), 0);
    bus.fpu_instr_ack = 1'b1;
    bus.fpu_busy      = 1'b1;
    step();
    bus.fpu_instr_ack = 1'b0;
    step();
    bus.fpu_busy = 1'b0;
    step();
    check("t3_rdy_idle", 32'(bus.cpu_ready), 0);
    step();
    check("t3_ins_b", 32'({bus.fpu_opcode, bus.fpu_modrm}), 32'hDCC9);
    check("t3_rdy_b", 32'(bus.cpu_ready), 0);
    bus.fpu_instr_ack = 1'b1;
    bus.fpu_busy      = 1'b1;
    step();
    bus.fpu_instr_ack = 1'b0;
    step();
    bus.fpu_busy = 1'b0;
    #1;
    check("t3_rdy_exec", 32'(bus.cpu_ready), 0);
    step();
    check("t3_rdy_rel", 32'(bus.cpu_ready), 1);
    bus.cpu_fwait = 1'b0;

    // watchdog on a never-acked instruction
    esc(8'hD9, 8'hFA);
    esc(8'hD9, 8'hFC);
    check("t4_to_pre", 32'(timeout), 0);
    n = 0;
    while (bus.fpu_instr_valid && n < 40) begin
      n++;
      step();
    end
    check("t4_cycles", n, 16);
    check("t4_to", 32'(timeout), 1);
    check("t4_lvl", 32'(queue_level), 1);
    step();
    check("t4_next", 32'({bus.fpu_opcode, bus.fpu_modrm}), 32'hD9FC);
    serve(got);
    check("t4_served", 32'(got), 32'hD9FC);

    // reset while an instruction is offered
    esc(8'hD8, 8'h01);
    esc(8'hD8, 8'h02);
    esc(8'hD8, 8'h03);
    check("t5_val_pre", 32'(bus.fpu_instr_valid), 1);
    check("t5_lvl_pre", 32'(queue_level), 2);
    reset_n = 1'b0;
    #2;
    check("t5_val", 32'(bus.fpu_instr_valid), 0);
    check("t5_lvl", 32'(queue_level), 0);
    check("t5_flags", 32'({overflow, timeout}), 0);
    #3 reset_n = 1'b1;
    n = 0;
    repeat (5) begin
      step();
      if (bus.fpu_instr_valid) n++;
    end
    check("t5_no_issue", n, 0);

    // push in the popping cycle, wrapping pointers
    esc(ent(0)[15:8], ent(0)[7:0]);
    check("t6_lvl0", 32'(queue_level), 1);
    esc(ent(1)[15:8], ent(1)[7:0]);
    check("t6_lvl1", 32'(queue_level), 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t6_val%0d", i), 32'(bus.fpu_instr_valid), 1);
      check($sformatf("t6_ins%0d", i),
            32'({bus.fpu_opcode, bus.fpu_modrm}), 32'(ent(i)));
      bus.fpu_instr_ack = 1'b1;
      bus.fpu_busy      = 1'b1;
      step();
      bus.fpu_instr_ack = 1'b0;
      bus.fpu_busy      = 1'b0;
      step();
      if (i + 2 < 10) begin
        esc(ent(i + 2)[15:8], ent(i + 2)[7:0]);
        check($sformatf("t6_lvl%0d", i + 2), 32'(queue_level), 1);
      end else begin
        step();
      end
    end
    check("t6_lvl_end", 32'(queue_level), 0);

    // second timeout, then clear
    esc(8'hDB, 8'hE3);
    step();
    n = 0;
    while (bus.fpu_instr_valid && n < 40) begin
      n++;
      step();
    end
    check("t7_to", 32'(timeout), 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t7_to_clr", 32'(timeout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
